// File: rtl/icache_tag_ctrl.sv
// -----------------------------------------------------------------------------
// icache_tag_ctrl
// Lookup and line-refill controller for a direct-mapped, read-only instruction
// cache. Compares each fetch address against the external TagRam plus the
// per-line valid bits held here, runs a 4-word refill burst on a miss, commits
// the new tag, and keeps saturating hit/miss counters.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   cpu_req, cpu_addr   fetch request / byte address (held until cpu_ready)
//   cpu_ready           hit this cycle, DataRam read data is valid
//   flush               invalidate every line (honoured in IDLE only)
//   tag_index           TagRam/DataRam line index
//   tag_out             TagRam read data (combinational from tag_index)
//   tag_we, tag_wdata   TagRam write strobe / data
//   data_we, data_word  DataRam word write strobe / word-within-line
//   mem_req, mem_addr   refill burst request / line-aligned address
//   mem_valid           refill word present on the DataRam write bus
//   hit_cnt, miss_cnt   saturating event counters
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | lookup on cpu_addr; hit answers combinationally, miss latches
// REFILL | burst in progress, one DataRam write per mem_valid beat
// UPDATE | single cycle writing the tag; line becomes valid at its end
// -----------------------------------------------------------------------------
module icache_tag_ctrl #(
   parameter int ADDR_WIDTH    = 32,
   parameter int INDEX_LENGTH  = 6,
   parameter int OFFSET_LENGTH = 4,
   parameter int TAG_LENGTH    = ADDR_WIDTH - INDEX_LENGTH - OFFSET_LENGTH,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cpu_req,
   input  logic [ADDR_WIDTH-1:0]    cpu_addr,
   output logic                     cpu_ready,
   input  logic                     flush,
   output logic [INDEX_LENGTH-1:0]  tag_index,
   input  logic [TAG_LENGTH-1:0]    tag_out,
   output logic                     tag_we,
   output logic [TAG_LENGTH-1:0]    tag_wdata,
   output logic                     data_we,
   output logic [1:0]               data_word,
   output logic                     mem_req,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   input  logic                     mem_valid,
   output logic [CNT_WIDTH-1:0]     hit_cnt,
   output logic [CNT_WIDTH-1:0]     miss_cnt
);

   localparam int IDX_LO = OFFSET_LENGTH;
   localparam int IDX_HI = OFFSET_LENGTH + INDEX_LENGTH - 1;
   localparam int TAG_LO = IDX_HI + 1;
   localparam int LINES  = 1 << INDEX_LENGTH;

   typedef enum logic [1:0] {IDLE, REFILL, UPDATE} state_t;

   state_t                          state, next_state;
   logic [LINES-1:0]                valid;
   logic [1:0]                      word_cnt;
   // Only the line address of a miss is needed; the byte offset is never used.
   logic [ADDR_WIDTH-1:IDX_LO]      miss_line;
   logic [INDEX_LENGTH-1:0]         miss_index;
   logic [TAG_LENGTH-1:0]           miss_tag;
   logic [TAG_LENGTH-1:0]           cpu_tag;
   logic                            hit;
   logic                            do_flush;
   logic                            do_miss;

   assign miss_index = miss_line[IDX_HI:IDX_LO];
   assign miss_tag   = miss_line[ADDR_WIDTH-1:TAG_LO];
   assign cpu_tag    = cpu_addr[ADDR_WIDTH-1:TAG_LO];
   assign tag_index  = (state == IDLE) ? cpu_addr[IDX_HI:IDX_LO] : miss_index;
   assign hit        = valid[tag_index] && (tag_out == cpu_tag);
   assign data_word  = word_cnt;

   always_comb begin
      next_state = state;
      cpu_ready  = 1'b0;
      tag_we     = 1'b0;
      tag_wdata  = '0;
      data_we    = 1'b0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      do_flush   = 1'b0;
      do_miss    = 1'b0;
      case (state)
         IDLE: begin
            if (flush) begin
               do_flush = 1'b1;
            end else if (cpu_req && hit) begin
               cpu_ready = 1'b1;
            end else if (cpu_req) begin
               do_miss    = 1'b1;
               next_state = REFILL;
            end
         end
         REFILL: begin
            mem_req  = 1'b1;
            mem_addr = {miss_line, {OFFSET_LENGTH{1'b0}}};
            data_we  = mem_valid;
            if (mem_valid && word_cnt == 2'd3) next_state = UPDATE;
         end
         UPDATE: begin
            tag_we     = 1'b1;
            tag_wdata  = miss_tag;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         valid     <= '0;
         word_cnt  <= 2'd0;
         miss_line <= '0;
         hit_cnt   <= '0;
         miss_cnt  <= '0;
      end else begin
         state <= next_state;
         if (do_flush) begin
            valid <= '0;
         end else if (do_miss) begin
            // Drop the old line now so a partially refilled line can never hit.
            valid[tag_index] <= 1'b0;
            miss_line        <= cpu_addr[ADDR_WIDTH-1:IDX_LO];
         end else if (state == UPDATE) begin
            valid[miss_index] <= 1'b1;
         end
         // Two-bit counter wraps 3 -> 0 on the last beat of the burst.
         if (data_we) word_cnt <= word_cnt + 2'd1;
         if (cpu_ready && hit_cnt != {CNT_WIDTH{1'b1}})
            hit_cnt <= hit_cnt + CNT_WIDTH'(1);
         if (do_miss && miss_cnt != {CNT_WIDTH{1'b1}})
            miss_cnt <= miss_cnt + CNT_WIDTH'(1);
      end
   end

endmodule
